// File: rtl/m_mem_loader_pkg.sv
// Shared sizing constants and state encoding for the modulus RAM loader.
// The same constants size the operand memories.
package m_mem_loader_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 7;
  localparam int TOTAL_ADDR     = 128;
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int BCNT_WIDTH     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_ADDR - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_FINISH   = 2'd3
  } state_e;

endpackage

// File: rtl/m_mem_loader_if.sv
// Byte-stream valid/ready handshake between the host bridge (master) and the loader (slave).
interface m_mem_loader_if;

  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_byte, output in_valid, input in_ready);
  modport slave  (input in_byte, input in_valid, output in_ready);

endinterface

// File: rtl/m_mem_loader_byte_packer.sv
// Packs accepted bytes little-endian into one RAM word; flags the push that completes it.
module m_mem_loader_byte_packer
  import m_mem_loader_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [7:0]            byte_i,
  output logic                  word_full_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [BCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  assign word_full_o = push_i && (cnt_q == BCNT_WIDTH'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (push_i) begin
      word_d[8*int'(cnt_q) +: 8] = byte_i;
      cnt_d = word_full_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/m_mem_loader.sv
// Byte-serial loader filling the modulus operand RAM, addresses 0..TOTAL_ADDR-1.
// state    | meaning
// IDLE     | waiting for start
// ASSEMBLE | accepting bytes into the current word
// WRITE    | one-cycle RAM write of the assembled word
// FINISH   | done pulse, then back to IDLE
module m_mem_loader
  import m_mem_loader_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  m_mem_loader_if.slave         in_if,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wren_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wren_q, wren_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pack_clear, pack_push, word_full;
  logic [DATA_WIDTH-1:0] pack_word;

  assign pack_push = in_if.in_valid && in_ready_q;

  m_mem_loader_byte_packer u_byte_packer (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clear_i     (pack_clear),
    .push_i      (pack_push),
    .byte_i      (in_if.in_byte),
    .word_full_o (word_full),
    .word_o      (pack_word)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      in_ready_q <= in_ready_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Abort arriving with the last byte of a word means that word never reaches wren.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    pack_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_ASSEMBLE;
          word_cnt_d = '0;
          pack_clear = 1'b1;
        end
      end
      ST_ASSEMBLE: begin
        if (abort_i)        state_d = ST_IDLE;
        else if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (word_cnt_q == LAST_ADDR) begin
          state_d = ST_FINISH;
        end else begin
          state_d    = ST_ASSEMBLE;
          word_cnt_d = word_cnt_q + 1'b1;
          pack_clear = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_d = (state_d == ST_ASSEMBLE);
    wren_d     = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FINISH);
  end

  assign in_if.in_ready = in_ready_q;
  assign wr_address_o   = word_cnt_q;
  assign wr_data_o      = pack_word;
  assign wren_o         = wren_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_m_mem_loader.sv
// Self-checking bench for m_mem_loader: byte source, write scoreboard and RAM image model.
module tb_m_mem_loader;
  import m_mem_loader_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wren;
  logic                  busy;
  logic                  done;

  m_mem_loader_if in_if ();

  m_mem_loader dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .start_i      (start),
    .abort_i      (abort),
    .in_if        (in_if),
    .wr_address_o (wr_address),
    .wr_data_o    (wr_data),
    .wren_o       (wren),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_t;

  wr_t                   sb[$];
  wr_t                   mon_e;
  int                    n_chk = 0;
  int                    n_pass = 0;
  int                    cyc = 0;
  int                    wren_cnt = 0;
  int                    done_cnt = 0;
  int                    done_cyc = 0;
  int                    start_cyc = 0;
  logic [DATA_WIDTH-1:0] ram     [TOTAL_ADDR];
  logic [DATA_WIDTH-1:0] exp_ram [TOTAL_ADDR];
  logic [DATA_WIDTH-1:0] m_word;
  int                    m_bcnt;
  int                    m_addr;
  logic [7:0]            nb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wren_cnt++;
      ram[wr_address] = wr_data;
      chk("ready_low_in_write", in_ready_val(), 0);
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", wr_address, mon_e.addr);
        chk("wr_data", wr_data, mon_e.data);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic in_ready_val();
    return in_if.in_ready;
  endfunction

  task automatic model_reset();
    m_word = '0;
    m_bcnt = 0;
    m_addr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t e;
    m_word[8*m_bcnt +: 8] = b;
    m_bcnt++;
    if (m_bcnt == BYTES_PER_WORD) begin
      e.addr = ADDR_WIDTH'(m_addr);
      e.data = m_word;
      sb.push_back(e);
      exp_ram[m_addr] = m_word;
      m_addr++;
      m_bcnt = 0;
      m_word = '0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_cyc = cyc;
    start = 1'b1;
    model_reset();
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap_pct);
    int   sent = 0;
    int   guard = 0;
    logic acc;
    while (sent < n && guard < 4000) begin
      if (!in_if.in_valid) begin
        if (int'($urandom_range(99)) >= gap_pct) begin
          in_if.in_valid = 1'b1;
          in_if.in_byte  = nb;
        end
      end
      @(negedge clk);
      acc = in_if.in_valid && in_if.in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        model_byte(in_if.in_byte);
        nb++;
        sent++;
        in_if.in_valid = 1'b0;
      end
    end
    chk("send_budget", sent, n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_if.in_ready, 0);
    chk({tag, "_wren"}, wren, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, wr_address, 0);
    chk({tag, "_data"}, wr_data, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_byte = 8'h00;
    nb = 8'h00;
    model_reset();
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(1);

    // full load, source always valid, bytes 0x00..0xFF repeating
    nb = 8'h00;
    wren_cnt = 0;
    done_cnt = 0;
    do_start();
    send_bytes(TOTAL_ADDR * BYTES_PER_WORD, 0);
    wait_idle("full_idle", 20);
    chk("full_wren_cnt", wren_cnt, TOTAL_ADDR);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_latency", done_cyc - start_cyc + 1, 642);
    chk("full_ram0", ram[0], 32'h03020100);
    chk("full_ram127", ram[127], 32'hFFFEFDFC);
    chk("full_sb_drain", sb.size(), 0);

    // abort after 6 bytes
    wren_cnt = 0;
    done_cnt = 0;
    do_start();
    send_bytes(6, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    m_bcnt = 0;
    m_word = '0;
    tick(6);
    chk("abort_wren_cnt", wren_cnt, 1);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_sb_drain", sb.size(), 0);

    // restart rewrites from address 0
    do_start();
    send_bytes(8, 20);
    tick(3);
    chk("restart_wren_cnt", wren_cnt, 3);
    chk("restart_sb_drain", sb.size(), 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("restart_abort_busy", busy, 0);
    m_bcnt = 0;
    m_word = '0;

    // start+abort together in IDLE, start pulse mid-word, random gaps
    wren_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    model_reset();
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 1);
    send_bytes(10, 30);
    chk("mid_ready", in_if.in_ready, 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    send_bytes(TOTAL_ADDR * BYTES_PER_WORD - 10, 30);
    wait_idle("rand_idle", 20);
    chk("rand_wren_cnt", wren_cnt, TOTAL_ADDR);
    chk("rand_done_cnt", done_cnt, 1);
    chk("rand_sb_drain", sb.size(), 0);
    for (int i = 0; i < TOTAL_ADDR; i++) chk("rand_ram_img", ram[i], exp_ram[i]);

    // reset during a WRITE cycle
    do_start();
    send_bytes(BYTES_PER_WORD, 0);
    chk("pre_rst_wren", wren, 1);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    m_bcnt = 0;
    m_word = '0;
    chk("mid_reset_sb_drain", sb.size(), 0);
    do_start();
    send_bytes(BYTES_PER_WORD, 0);
    tick(2);
    chk("post_reset_sb_drain", sb.size(), 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("post_reset_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
